// File: rtl/traffic_light_monitor.sv
// Receive-side observer for traffic-light lamp lines: decodes the phase on each tick,
// flags illegal lamp combinations, illegal phase order and bad dwell times, and counts cycles.
module traffic_light_monitor #(
  parameter int unsigned TIME_RED    = 30,
  parameter int unsigned TIME_YELLOW = 3,
  parameter int unsigned TIME_GREEN  = 20,
  parameter int unsigned TOL         = 2,
  parameter int unsigned CNT_W       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_i,
  input  logic [2:0] lights_i,
  input  logic       clear_i,
  output logic [2:0] phase_o,
  output logic       phase_change_o,
  output logic       err_combo_o,
  output logic       err_seq_o,
  output logic       err_time_o,
  output logic [7:0] cycles_o
);

  typedef enum logic [2:0] {
    PH_OFF = 3'd0,
    PH_RED = 3'd1,
    PH_RY  = 3'd2,
    PH_GRN = 3'd3,
    PH_YEL = 3'd4,
    PH_ILL = 3'd7
  } phase_e;

  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [7:0]       CYC_MAX   = 8'hFF;

  phase_e           phase_q, phase_d, sample_ph;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic             pc_q, pc_d;
  logic             err_combo_q, err_combo_d;
  logic             err_seq_q, err_seq_d;
  logic             err_time_q, err_time_d;
  logic [7:0]       cycles_q, cycles_d;

  // Nominal dwell of the phase being left.
  function automatic int unsigned nominal_time(input phase_e ph);
    case (ph)
      PH_RED:        return TIME_RED;
      PH_RY, PH_YEL: return TIME_YELLOW;
      PH_GRN:        return TIME_GREEN;
      default:       return 0;
    endcase
  endfunction

  // A saturated counter no longer holds the true dwell, so it never passes.
  function automatic logic dwell_ok(input logic [CNT_W-1:0] dwell, input int unsigned t);
    int unsigned lo;
    int unsigned hi;
    int unsigned d;
    lo = (t > TOL) ? (t - TOL) : 0;
    hi = t + TOL;
    d  = 32'(dwell);
    return (dwell != DWELL_MAX) && (d >= lo) && (d <= hi);
  endfunction

  // Lamp decode, {red, yellow, green}.
  always_comb begin
    case (lights_i)
      3'b000:  sample_ph = PH_OFF;
      3'b100:  sample_ph = PH_RED;
      3'b110:  sample_ph = PH_RY;
      3'b001:  sample_ph = PH_GRN;
      3'b010:  sample_ph = PH_YEL;
      default: sample_ph = PH_ILL;
    endcase
  end

  // Next-state and flag logic.
  always_comb begin
    logic       combo_set;
    logic       seq_set;
    logic       time_set;
    logic       cyc_inc;
    logic       legal;
    logic       timed;
    logic [7:0] cyc_base;

    phase_d   = phase_q;
    dwell_d   = dwell_q;
    pc_d      = 1'b0;
    combo_set = 1'b0;
    seq_set   = 1'b0;
    time_set  = 1'b0;
    cyc_inc   = 1'b0;
    legal     = 1'b0;
    timed     = 1'b0;

    if (tick_i) begin
      combo_set = (sample_ph == PH_ILL);
      if (sample_ph == phase_q) begin
        if (dwell_q != DWELL_MAX) dwell_d = dwell_q + CNT_W'(1);
      end else begin
        phase_d = sample_ph;
        dwell_d = CNT_W'(1);
        pc_d    = 1'b1;
        legal   = (sample_ph == PH_OFF) || (sample_ph == PH_ILL) || (phase_q == PH_ILL) ||
                  (phase_q == PH_OFF && sample_ph == PH_RED) ||
                  (phase_q == PH_RED && sample_ph == PH_RY)  ||
                  (phase_q == PH_RY  && sample_ph == PH_GRN) ||
                  (phase_q == PH_GRN && sample_ph == PH_YEL) ||
                  (phase_q == PH_YEL && sample_ph == PH_RED);
        seq_set = !legal;
        timed   = (phase_q == PH_RED || phase_q == PH_RY || phase_q == PH_GRN ||
                   phase_q == PH_YEL) && (sample_ph != PH_OFF) && (sample_ph != PH_ILL);
        time_set = timed && !dwell_ok(dwell_q, nominal_time(phase_q));
        cyc_inc  = (phase_q == PH_YEL) && (sample_ph == PH_RED);
      end
    end

    // A set or increment on the clearing edge wins over the clear.
    err_combo_d = (err_combo_q & ~clear_i) | combo_set;
    err_seq_d   = (err_seq_q   & ~clear_i) | seq_set;
    err_time_d  = (err_time_q  & ~clear_i) | time_set;
    cyc_base    = clear_i ? 8'd0 : cycles_q;
    if (cyc_inc && cyc_base != CYC_MAX) cycles_d = cyc_base + 8'd1;
    else                                cycles_d = cyc_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q     <= PH_OFF;
      dwell_q     <= '0;
      pc_q        <= 1'b0;
      err_combo_q <= 1'b0;
      err_seq_q   <= 1'b0;
      err_time_q  <= 1'b0;
      cycles_q    <= 8'd0;
    end else begin
      phase_q     <= phase_d;
      dwell_q     <= dwell_d;
      pc_q        <= pc_d;
      err_combo_q <= err_combo_d;
      err_seq_q   <= err_seq_d;
      err_time_q  <= err_time_d;
      cycles_q    <= cycles_d;
    end
  end

  assign phase_o        = phase_q;
  assign phase_change_o = pc_q;
  assign err_combo_o    = err_combo_q;
  assign err_seq_o      = err_seq_q;
  assign err_time_o     = err_time_q;
  assign cycles_o       = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: directed lamp segments push expected
// per-tick outputs; a monitor pops and compares after every tick edge.
module tb_traffic_light_monitor;

  logic       clk;
  logic       rst_n;
  logic       tick_i;
  logic [2:0] lights_i;
  logic       clear_i;
  logic [2:0] phase_o;
  logic       phase_change_o;
  logic       err_combo_o;
  logic       err_seq_o;
  logic       err_time_o;
  logic [7:0] cycles_o;

  traffic_light_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .tick_i         (tick_i),
    .lights_i       (lights_i),
    .clear_i        (clear_i),
    .phase_o        (phase_o),
    .phase_change_o (phase_change_o),
    .err_combo_o    (err_combo_o),
    .err_seq_o      (err_seq_o),
    .err_time_o     (err_time_o),
    .cycles_o       (cycles_o)
  );

  typedef struct {
    logic [2:0] ph;
    logic       pc;
    logic [2:0] err;   // {combo, seq, time}
    logic [7:0] cyc;
    int         tag;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         checks   = 0;
  int         errors   = 0;
  int         pc_count = 0;
  int         seg_id   = 0;
  logic [2:0] prev_ph  = 3'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s seg%0d: got %0d expected %0d", nm, tag, act, exp);
    end
  endtask

  // Monitor: every tick edge must have a queued expectation.
  always @(posedge clk) begin
    if (rst_n && tick_i) begin
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: output with empty scoreboard at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        if (phase_change_o) pc_count++;
        check("phase",        mon_e.tag, int'(phase_o), int'(mon_e.ph));
        check("phase_change", mon_e.tag, int'(phase_change_o), int'(mon_e.pc));
        check("err_flags",    mon_e.tag, int'({err_combo_o, err_seq_o, err_time_o}), int'(mon_e.err));
        check("cycles",       mon_e.tag, int'(cycles_o), int'(mon_e.cyc));
      end
    end else if (rst_n) begin
      #1;
      check("pc_idle", seg_id, int'(phase_change_o), 0);
    end
  end

  // n ticks of one lamp pattern; flags and cycles are constant across the whole segment.
  task automatic seg(input logic [2:0] l, input logic [2:0] ph, input int n,
                     input logic [2:0] err, input int cyc, input bit clr = 1'b0);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      lights_i = l;
      tick_i   = 1'b1;
      clear_i  = clr && (i == 0);
      e.ph  = ph;
      e.pc  = (i == 0) && (ph != prev_ph);
      e.err = err;
      e.cyc = 8'(cyc);
      e.tag = seg_id;
      sb.push_back(e);
      @(negedge clk);
      tick_i   = 1'b0;
      clear_i  = 1'b0;
      lights_i = 3'($urandom);
    end
    prev_ph = ph;
    seg_id++;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", seg_id, sb.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    check(nm, seg_id, int'({phase_o, phase_change_o, err_combo_o, err_seq_o, err_time_o, cycles_o}), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    tick_i   = 1'b0;
    clear_i  = 1'b0;
    lights_i = 3'b000;
    repeat (3) @(negedge clk);
    check_zero("reset_values");
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal cycle
    seg(3'b000, 3'd0,  1, 3'b000, 0);
    seg(3'b100, 3'd1, 31, 3'b000, 0);
    seg(3'b110, 3'd2,  3, 3'b000, 0);
    seg(3'b001, 3'd3, 20, 3'b000, 0);
    seg(3'b010, 3'd4,  3, 3'b000, 0);
    seg(3'b100, 3'd1,  1, 3'b000, 1);
    drain();
    check("pc_pulses", seg_id, pc_count, 5);

    // Illegal combination inside RED, then recovery
    seg(3'b100, 3'd1,  9, 3'b000, 1);
    seg(3'b111, 3'd7,  1, 3'b100, 1);
    seg(3'b100, 3'd1,  5, 3'b100, 1);

    // Order violation RED(30) -> GRN
    seg(3'b100, 3'd1, 25, 3'b000, 0, 1'b1);
    seg(3'b001, 3'd3,  1, 3'b010, 0);

    // Dwell bounds
    seg(3'b000, 3'd0,  1, 3'b000, 0, 1'b1);
    seg(3'b100, 3'd1, 27, 3'b000, 0);
    seg(3'b110, 3'd2,  3, 3'b001, 0);
    seg(3'b000, 3'd0,  1, 3'b000, 0, 1'b1);
    seg(3'b100, 3'd1, 32, 3'b000, 0);
    seg(3'b110, 3'd2,  3, 3'b000, 0);
    seg(3'b001, 3'd3, 23, 3'b000, 0);
    seg(3'b010, 3'd4,  3, 3'b001, 0);
    seg(3'b100, 3'd1,  1, 3'b001, 1);
    seg(3'b000, 3'd0,  1, 3'b000, 0, 1'b1);
    seg(3'b100, 3'd1, 28, 3'b000, 0);
    seg(3'b110, 3'd2,  1, 3'b000, 0);
    seg(3'b001, 3'd3, 18, 3'b000, 0);
    seg(3'b010, 3'd4,  5, 3'b000, 0);
    seg(3'b100, 3'd1, 33, 3'b000, 1);
    seg(3'b110, 3'd2,  6, 3'b001, 1);
    seg(3'b001, 3'd3,  1, 3'b001, 1);
    // Saturated dwell
    seg(3'b000, 3'd0,  1, 3'b000, 0, 1'b1);
    seg(3'b100, 3'd1, 70, 3'b000, 0);
    seg(3'b110, 3'd2,  3, 3'b001, 0);

    // Clear collision with a GRN->RED order error at cycles_o=5
    seg(3'b001, 3'd3, 20, 3'b000, 0, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      seg(3'b010, 3'd4,  3, 3'b000, k - 1);
      seg(3'b100, 3'd1, 30, 3'b000, k);
      seg(3'b110, 3'd2,  3, 3'b000, k);
      seg(3'b001, 3'd3, 20, 3'b000, k);
    end
    seg(3'b000, 3'd0,  1, 3'b000, 5);
    seg(3'b001, 3'd3, 20, 3'b010, 5);
    seg(3'b100, 3'd1,  2, 3'b010, 0, 1'b1);

    // Async reset during GRN dwell 10
    seg(3'b000, 3'd0,  1, 3'b010, 0);
    seg(3'b001, 3'd3, 10, 3'b010, 0);
    drain();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rst_n   = 1'b1;
    prev_ph = 3'd0;
    seg(3'b001, 3'd3, 20, 3'b010, 0);
    seg(3'b010, 3'd4,  3, 3'b010, 0);

    // Cycle counter saturation
    seg(3'b100, 3'd1, 30, 3'b000, 1, 1'b1);
    for (int i = 0; i < 260; i++) begin
      int c1;
      int c2;
      c1 = (i + 1 > 255) ? 255 : i + 1;
      c2 = (i + 2 > 255) ? 255 : i + 2;
      seg(3'b110, 3'd2,  3, 3'b000, c1);
      seg(3'b001, 3'd3, 20, 3'b000, c1);
      seg(3'b010, 3'd4,  3, 3'b000, c1);
      seg(3'b100, 3'd1, 30, 3'b000, c2);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
